// File: rtl/maxnet_pkg.sv
// maxnet_pkg: scheduler state encoding and error codes shared by the Maxnet control blocks
package maxnet_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT, S_SETTLE, S_CHECK, S_DONE, S_FAIL
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ZERO    = 2'd2;
  localparam logic [1:0] ERR_ITER    = 2'd3;
endpackage

// File: rtl/maxnet_onehot_chk.sv
// maxnet_onehot_chk: classifies the nonzero vector as empty, single survivor, or more, and locates the lowest survivor
module maxnet_onehot_chk #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  nz_vec,
  output logic          is_zero,
  output logic          is_one,
  output logic [IW-1:0] idx
);
  assign is_zero = ~|nz_vec;
  assign is_one  = !is_zero && ((nz_vec & (nz_vec - N'(1))) == '0);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (nz_vec[i]) idx = IW'(i);
  end
endmodule

// File: rtl/maxnet_sched.sv
// maxnet_sched: iterates PLU passes until one neuron survives, with timeout, all-zero and iteration-limit exits
module maxnet_sched import maxnet_pkg::*; #(
  parameter int N        = 4,
  parameter int MAX_ITER = 16,
  parameter int TIMEOUT  = 64,
  parameter int IW       = $clog2(N),
  parameter int ITW      = $clog2(MAX_ITER + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           plu_done,
  input  logic [N-1:0]   nz_vec,
  output logic           start_plu,
  output logic           we_a_reg,
  output logic           we_prim,
  output logic           eps_reg_we,
  output logic           mux_sel,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [IW-1:0]  winner,
  output logic           winner_vld,
  output logic [ITW-1:0] iter_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic is_zero, is_one, tmo, at_lim, kill;
  logic [IW-1:0] idx;
  maxnet_onehot_chk #(.N(N), .IW(IW)) u_chk (
    .nz_vec (nz_vec),
    .is_zero(is_zero),
    .is_one (is_one),
    .idx    (idx)
  );
  // timer counts WAIT cycles from 0, so FAIL lands exactly TIMEOUT cycles after KICK
  assign tmo    = timer == TW'(TIMEOUT - 2);
  assign at_lim = iter_cnt == ITW'(MAX_ITER);
  assign kill   = abort && state != S_IDLE;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = start ? S_LOAD : S_IDLE;
      S_LOAD:   nxt = S_KICK;
      S_KICK:   nxt = S_WAIT;
      S_WAIT:   nxt = plu_done ? S_SETTLE : tmo ? S_FAIL : S_WAIT;
      S_SETTLE: nxt = S_CHECK;
      S_CHECK:  nxt = is_one ? S_DONE : (is_zero || at_lim) ? S_FAIL : S_KICK;
      default:  nxt = S_IDLE;
    endcase
    if (kill) nxt = S_IDLE;
  end
  assign start_plu  = state == S_KICK;
  assign we_a_reg   = state == S_LOAD;
  assign we_prim    = state == S_LOAD;
  assign eps_reg_we = state == S_LOAD;
  assign mux_sel    = state == S_LOAD;
  assign busy       = state != S_IDLE;
  assign done       = state == S_DONE;
  assign err        = state == S_FAIL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      iter_cnt   <= '0;
      winner     <= '0;
      winner_vld <= 1'b0;
      err_code   <= ERR_NONE;
    end else if (kill) begin
      winner_vld <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      if (state == S_IDLE && start) begin
        winner_vld <= 1'b0;
        err_code   <= ERR_NONE;
        iter_cnt   <= '0;
      end
      if (state == S_KICK) timer <= '0;
      if (state == S_WAIT && !plu_done) timer <= timer + 1'b1;
      if (state == S_WAIT && !plu_done && tmo) err_code <= ERR_TIMEOUT;
      if (state == S_SETTLE) iter_cnt <= iter_cnt + 1'b1;
      if (state == S_CHECK && is_one) begin
        winner     <= idx;
        winner_vld <= 1'b1;
      end
      if (state == S_CHECK && !is_one)
        err_code <= is_zero ? ERR_ZERO : at_lim ? ERR_ITER : ERR_NONE;
    end
  end
endmodule

// File: tb/tb_maxnet_sched.sv
// tb_maxnet_sched: directed and randomized runs of maxnet_sched checked against a pass-level reference model
module tb_maxnet_sched;
  localparam int N = 4, MAX_ITER = 16, TIMEOUT = 64, IW = 2, ITW = 5, PL = MAX_ITER + 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, plu_done = 1'b0;
  logic [N-1:0] nz_vec = '0;
  logic start_plu, we_a_reg, we_prim, eps_reg_we, mux_sel, busy, done, err, winner_vld;
  logic [1:0] err_code;
  logic [IW-1:0] winner;
  logic [ITW-1:0] iter_cnt;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  maxnet_sched #(.N(N), .MAX_ITER(MAX_ITER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .plu_done(plu_done),
    .nz_vec(nz_vec), .start_plu(start_plu), .we_a_reg(we_a_reg), .we_prim(we_prim),
    .eps_reg_we(eps_reg_we), .mux_sel(mux_sel), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .winner(winner), .winner_vld(winner_vld), .iter_cnt(iter_cnt)
  );
  // per-pass stimulus plan: nz after pass p, plu_done delay into WAIT (-1 = never)
  logic [N-1:0] plan_nz[PL];
  int plan_dly[PL];
  int abort_kick, abort_off;
  bit busy_start, spur, start_abort;
  int r_kicks, r_loads, r_end_c;
  bit r_done, r_err, r_aborted;
  logic [3:0] r_ld1;
  logic r_wv_load, r_wv;
  logic [1:0] r_ec;
  logic [IW-1:0] r_win;
  logic [ITW-1:0] r_ic;
  int e_kicks, e_end, e_ec, e_ic, e_win;
  bit e_done, e_err;

  task automatic clear_plan();
    for (int i = 0; i < PL; i++) begin plan_nz[i] = '0; plan_dly[i] = 0; end
    abort_kick = 0; abort_off = 0; busy_start = 0; spur = 0; start_abort = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // drives one run from the plan; cycle c=1 is the cycle after start is sampled
  task automatic drive_run();
    int c, pd_at, ab_at, ki;
    bit fin;
    r_kicks = 0; r_loads = 0; r_end_c = -1; r_done = 0; r_err = 0; r_aborted = 0;
    fin = 0; pd_at = -100; ab_at = -100;
    start = 1'b1; abort = start_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; c = 1;
    while (!fin && c < 3000) begin
      if (c == 1) begin r_ld1 = {we_a_reg, we_prim, eps_reg_we, mux_sel}; r_wv_load = winner_vld; end
      if (we_a_reg | we_prim | eps_reg_we | mux_sel) r_loads++;
      if (start_plu) begin
        ki = r_kicks < PL ? r_kicks : PL - 1;
        pd_at = plan_dly[ki] < 0 ? -100 : c + 1 + plan_dly[ki];
        nz_vec = plan_nz[ki];
        r_kicks++;
        if (r_kicks == abort_kick) ab_at = c + abort_off;
      end
      plu_done = (c == pd_at) || (spur && (c == pd_at + 1 || start_plu));
      abort = (c == ab_at);
      start = busy_start && c >= 3 && c <= 5;
      if (done || err || !busy) begin
        r_done = done; r_err = err; r_aborted = !busy; r_end_c = c;
        r_ec = err_code; r_win = winner; r_wv = winner_vld; r_ic = iter_cnt;
        fin = 1;
      end else begin
        @(posedge clk); #1; c++;
      end
    end
    plu_done = 1'b0; abort = 1'b0; start = 1'b0;
    if (!fin) begin n_chk++; n_fail++; $display("FAIL run_bound: run did not end after %0d cycles", c); end
  endtask

  // reference: walks the plan pass by pass; each pass costs KICK + (delay+1) WAIT + SETTLE + CHECK
  task automatic model();
    int k0, ones;
    k0 = 2; e_done = 0; e_err = 0; e_ec = 0; e_ic = 0; e_kicks = 0; e_end = -1; e_win = 0;
    for (int p = 0; p < MAX_ITER; p++) begin
      e_kicks = p + 1;
      if (plan_dly[p] < 0 || plan_dly[p] > TIMEOUT - 2) begin
        e_err = 1; e_ec = 1; e_ic = p; e_end = k0 + TIMEOUT; break;
      end
      e_ic = p + 1;
      e_end = k0 + plan_dly[p] + 4;
      ones = $countones(plan_nz[p]);
      if (ones == 1) begin
        e_done = 1;
        for (int b = N - 1; b >= 0; b--) if (plan_nz[p][b]) e_win = b;
        break;
      end
      if (ones == 0) begin e_err = 1; e_ec = 2; break; end
      if (p + 1 == MAX_ITER) begin e_err = 1; e_ec = 3; break; end
      k0 = e_end;
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({start_plu, we_a_reg, we_prim, eps_reg_we, mux_sel, busy, done, err, err_code, winner, winner_vld, iter_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b iter=%0d want all 0", busy, done, err, iter_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_plan(); plan_dly[0] = -1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    idle(2);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({start_plu, we_a_reg, we_prim, eps_reg_we, mux_sel, busy, done, err, err_code, winner, winner_vld, iter_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_async: got busy=%b err_code=%0d iter=%0d want all 0", busy, err_code, iter_cnt);
    end
    #1 rst_n = 1'b1;
    idle(3);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_single();
    clear_plan(); plan_nz[0] = 4'b0100; start_abort = 1;
    drive_run();
    n_chk++; if (r_ld1 !== 4'hF) begin n_fail++; $display("FAIL single_load_en: got %b want 1111", r_ld1); end
    n_chk++; if (r_loads != 1) begin n_fail++; $display("FAIL single_load_cycles: got %0d want 1", r_loads); end
    n_chk++; if (!r_done || r_end_c != 6) begin n_fail++; $display("FAIL single_done_cycle: got done=%0d at %0d want 1 at 6", r_done, r_end_c); end
    n_chk++; if (r_win !== 2'd2 || r_wv !== 1'b1) begin n_fail++; $display("FAIL single_winner: got %0d vld=%b want 2 vld=1", r_win, r_wv); end
    n_chk++; if (r_ic !== 5'd1 || r_ec !== 2'd0) begin n_fail++; $display("FAIL single_iter: got iter=%0d ec=%0d want 1 0", r_ic, r_ec); end
    idle(4);
    n_chk++;
    if (winner !== 2'd2 || winner_vld !== 1'b1 || iter_cnt !== 5'd1 || busy || done) begin
      n_fail++; $display("FAIL single_hold: got win=%0d vld=%b iter=%0d busy=%b want 2 1 1 0", winner, winner_vld, iter_cnt, busy);
    end
  endtask

  task automatic test_multi();
    clear_plan(); plan_nz[0] = 4'b1011; plan_nz[1] = 4'b1011; plan_nz[2] = 4'b0001; busy_start = 1; spur = 1;
    drive_run();
    n_chk++; if (r_wv_load !== 1'b0) begin n_fail++; $display("FAIL multi_vld_clear: got %b want 0", r_wv_load); end
    n_chk++; if (r_kicks != 3) begin n_fail++; $display("FAIL multi_kicks: got %0d want 3", r_kicks); end
    n_chk++; if (r_loads != 1) begin n_fail++; $display("FAIL multi_busy_start: got %0d loads want 1", r_loads); end
    n_chk++; if (!r_done || r_end_c != 14 || r_win !== 2'd0 || r_ic !== 5'd3) begin
      n_fail++; $display("FAIL multi_result: got done=%0d c=%0d win=%0d iter=%0d want 1 14 0 3", r_done, r_end_c, r_win, r_ic);
    end
    idle(2);
  endtask

  task automatic test_errors();
    clear_plan(); plan_dly[0] = -1;
    drive_run();
    n_chk++; if (!r_err || r_end_c != 2 + TIMEOUT || r_ec !== 2'd1 || r_ic !== 5'd0 || r_wv !== 1'b0) begin
      n_fail++; $display("FAIL timeout: got err=%0d c=%0d ec=%0d iter=%0d want 1 %0d 1 0", r_err, r_end_c, r_ec, r_ic, 2 + TIMEOUT);
    end
    idle(2);
    clear_plan(); plan_nz[0] = 4'b0000; plan_dly[0] = 2;
    drive_run();
    n_chk++; if (!r_err || r_end_c != 8 || r_ec !== 2'd2 || r_ic !== 5'd1) begin
      n_fail++; $display("FAIL all_zero: got err=%0d c=%0d ec=%0d iter=%0d want 1 8 2 1", r_err, r_end_c, r_ec, r_ic);
    end
    idle(2);
    clear_plan();
    for (int i = 0; i < PL; i++) plan_nz[i] = 4'b0011;
    drive_run();
    n_chk++; if (!r_err || r_ec !== 2'd3 || r_ic !== 5'd16 || r_kicks != 16 || r_end_c != 66) begin
      n_fail++; $display("FAIL iter_limit: got err=%0d ec=%0d iter=%0d kicks=%0d c=%0d want 1 3 16 16 66", r_err, r_ec, r_ic, r_kicks, r_end_c);
    end
    idle(2);
  endtask

  task automatic test_abort();
    bit seen;
    clear_plan(); plan_nz[0] = 4'b1011; plan_dly[1] = 3; plan_nz[1] = 4'b0001; abort_kick = 2; abort_off = 1;
    drive_run();
    n_chk++; if (!r_aborted || r_end_c != 8 || r_ec !== 2'd0 || r_wv !== 1'b0) begin
      n_fail++; $display("FAIL abort_wait: got idle=%0d c=%0d ec=%0d vld=%b want 1 8 0 0", r_aborted, r_end_c, r_ec, r_wv);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin seen |= done | err | busy; @(posedge clk); #1; end
    n_chk++; if (seen) begin n_fail++; $display("FAIL abort_quiet: got activity=1 want 0"); end
    clear_plan(); plan_nz[0] = 4'b0010; abort_kick = 1; abort_off = 1;
    drive_run();
    n_chk++; if (!r_aborted || r_end_c != 4 || r_ic !== 5'd0 || r_wv !== 1'b0) begin
      n_fail++; $display("FAIL abort_with_done: got idle=%0d c=%0d iter=%0d vld=%b want 1 4 0 0", r_aborted, r_end_c, r_ic, r_wv);
    end
    idle(2);
  endtask

  task automatic test_random();
    int np, r;
    logic [N-1:0] v;
    for (int t = 0; t < 30; t++) begin
      clear_plan();
      busy_start = $urandom_range(0, 1); spur = $urandom_range(0, 1);
      np = $urandom_range(1, 6);
      for (int p = 0; p < PL; p++) begin
        r = $urandom_range(0, 9);
        do v = N'($urandom_range(0, 15)); while ($countones(v) < 2);
        if (p == np - 1) v = r < 6 ? N'(1 << $urandom_range(0, N - 1)) : r < 8 ? '0 : v;
        plan_nz[p] = v;
        plan_dly[p] = $urandom_range(0, 20) == 0 ? TIMEOUT + 5 : $urandom_range(0, 5);
      end
      if ($urandom_range(0, 7) == 0) plan_dly[0] = TIMEOUT - 2;
      model();
      drive_run();
      n_chk++;
      if (r_done != e_done || r_err != e_err || r_end_c != e_end || r_kicks != e_kicks || r_loads != 1 ||
          r_ic !== ITW'(e_ic) || r_ec !== 2'(e_ec) || r_wv !== e_done || (e_done && r_win !== IW'(e_win))) begin
        n_fail++;
        $display("FAIL random_%0d: got done=%0d err=%0d c=%0d kicks=%0d iter=%0d ec=%0d win=%0d want %0d %0d %0d %0d %0d %0d %0d",
                 t, r_done, r_err, r_end_c, r_kicks, r_ic, r_ec, r_win, e_done, e_err, e_end, e_kicks, e_ic, e_ec, e_win);
      end
      idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    clear_plan();
    test_reset();
    test_single();
    test_multi();
    test_errors();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maxnet_sched.md
# maxnet_sched

Iteration scheduler for the Maxnet datapath. It loads the activation, weight and epsilon registers, then repeatedly starts the PLU and waits for its done. After each pass it checks the post-update nonzero vector. It stops when exactly one neuron survives, and reports the winner index and the number of iterations used. It also stops with an error code on PLU timeout, when every neuron dies, or when the iteration limit is reached. It sits between the top-level start/done handshake and the PLU/register-file enables.

## Interface
- N, 4: neuron count (≥2)
- MAX_ITER, 16: iteration limit (≥1)
- TIMEOUT, 64: max cycles to wait for plu_done (≥2)
- IW, $clog2(N): winner index width
- ITW, $clog2(MAX_ITER+1): iteration counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel the current run
- plu_done  in  1  PLU pass complete, single-cycle pulse
- nz_vec  in  N  bit i = activation i nonzero after the last update
- start_plu  out  1  PLU start pulse
- we_a_reg  out  1  activation register write enable
- we_prim  out  1  primary input register write enable
- eps_reg_we  out  1  epsilon register write enable
- mux_sel  out  1  1 = select external load path
- busy  out  1  high outside IDLE
- done  out  1  one-cycle success pulse
- err  out  1  one-cycle failure pulse
- err_code  out  2  0 none, 1 timeout, 2 all-zero, 3 iteration limit
- winner  out  IW  surviving neuron index
- winner_vld  out  1  winner holds a valid result
- iter_cnt  out  ITW  completed PLU passes in the current or last run

## Operation
States: IDLE, LOAD, KICK, WAIT, SETTLE, CHECK, DONE, FAIL. All enables are Moore outputs, 0 unless stated.
- **IDLE:** start=1 → LOAD; also clear winner_vld, err_code and iter_cnt.
- **LOAD:** we_a_reg, we_prim, eps_reg_we and mux_sel = 1 for exactly one cycle → KICK.
- **KICK:** start_plu=1 for one cycle; timer←0 → WAIT.
- **WAIT:** plu_done=1 → SETTLE. Otherwise timer++. When timer reaches TIMEOUT-1 without plu_done → FAIL with err_code=1.
- **SETTLE:** one write-back cycle; iter_cnt++ → CHECK.
- **CHECK:** count ones in nz_vec.
  - Exactly 1: winner←index of the set bit, winner_vld←1 → DONE.
  - 0: → FAIL with err_code=2.
  - 2 or more, iter_cnt==MAX_ITER: → FAIL with err_code=3.
  - 2 or more, otherwise: → KICK.
- **DONE:** done=1 → IDLE.
- **FAIL:** err=1 → IDLE.
- **abort:** abort=1 in any state other than IDLE forces IDLE on the next edge. It has priority over every other transition. No done or err pulse is produced, err_code=0, winner_vld=0.
- **Ignored inputs:** start while busy is ignored. plu_done outside WAIT is ignored.
- **Held results:** winner, winner_vld, err_code and iter_cnt hold their values until the next start is accepted.

## Timing
- **Reset:** state=IDLE and every output 0; the timer is 0.
- **Single run:** start is sampled at edge 0.
  - LOAD is in cycle 1 and KICK in cycle 2.
  - WAIT begins in cycle 3.
  - If plu_done arrives in WAIT cycle k, SETTLE is k+1, CHECK is k+2, and DONE or FAIL (or KICK) is k+3.
  - A one-iteration run with an immediate plu_done gives done in cycle 6.
- **Per-iteration minimum:** 4 cycles (KICK, WAIT, SETTLE, CHECK).
- **Timeout:** FAIL is entered exactly TIMEOUT cycles after KICK.
- **Simultaneous events:**
  - abort together with plu_done → IDLE.
  - start together with abort in IDLE → start accepted.
- **Reset mid-run:** immediate return to IDLE with all outputs 0.

## Structure
- **maxnet_pkg:** state enumeration; err_code constants ERR_NONE, ERR_TIMEOUT, ERR_ZERO, ERR_ITER.
- **maxnet_onehot_chk sub-module:** combinational, parameter N. Takes nz_vec and outputs is_zero, is_one and idx[IW-1:0] (lowest set bit).
- **Top module:** contains the state machine, timer and iteration counter.

## Test plan
- Reset with rst_n low mid-WAIT → all outputs 0 and state IDLE on the same edge, with no clock required.
- start, plu_done 1 cycle after KICK, nz_vec=4'b0100 → LOAD enables for one cycle, done in cycle 6, winner=2, winner_vld=1, iter_cnt=1.
- nz_vec=4'b1011 for 2 passes, then 4'b0001 → three start_plu pulses; done with winner=0, iter_cnt=3.
- plu_done never asserted with TIMEOUT=64 → err pulse 64 cycles after KICK, err_code=1, iter_cnt=0.
- nz_vec=0 at CHECK → err_code=2. nz_vec=4'b0011 permanently with MAX_ITER=16 → err_code=3 and iter_cnt=16 after 16 start_plu pulses.
- abort during the 2nd WAIT → IDLE next cycle, no done/err pulse, busy=0. start during busy → ignored, with no extra LOAD.
